scalar_rf_arbiter: RTL and testbench

SCALAR_RF_ARBITER -- requirements
Module: scalar_rf_arbiter

---
 rtl/scalar_rf_arbiter_pkg.sv | 25 ++
 rtl/scalar_rf_arbiter_rr.sv | 33 +++
 rtl/scalar_rf_arbiter.sv | 116 +++++++++++
 tb/tb_scalar_rf_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scalar_rf_arbiter_pkg.sv
// Shared scalar-unit constants and helpers for the scalar register-file arbiter.
// Holds default parameter values and index arithmetic for packed per-requester buses.
package scalar_rf_arbiter_pkg;

    localparam int unsigned DEF_NREQ       = 3;
    localparam int unsigned DEF_REG_DEPTH  = 6;
    localparam int unsigned DEF_REG_WIDTH  = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 5;

    // Width of an index into n items, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Lowest bit of slice idx in a packed bus of w-bit slices.
    function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

    // (i + 1) mod n without a divider.
    function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
        return ((i + 1) >= n) ? 0 : (i + 1);
    endfunction

endpackage

// File: rtl/scalar_rf_arbiter_rr.sv
// Round-robin grant: first asserted request at or above ptr, wrapping modulo NREQ.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter
    import scalar_rf_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned IW   = idx_width(DEF_NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx
);

    logic          found;
    logic [IW-1:0] pos;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = IW'((32'(ptr) + k) % NREQ);
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                grant_idx  = pos;
            end
        end
    end

endmodule

// File: rtl/scalar_rf_arbiter.sv
// Arbitrates NREQ requesters onto one scalar register file port pair.
// Grants are combinational; responses arrive one cycle after the accept.
module scalar_rf_arbiter
    import scalar_rf_arbiter_pkg::*;
#(
    parameter int unsigned NREQ       = DEF_NREQ,
    parameter int unsigned REG_DEPTH  = DEF_REG_DEPTH,
    parameter int unsigned REG_WIDTH  = DEF_REG_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0]           req_we,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*REG_WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]           req_ready,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [REG_WIDTH-1:0]      rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_WIDTH-1:0]     rf_read_address,
    output logic [ADDR_WIDTH-1:0]     rf_write_address,
    output logic [REG_WIDTH-1:0]      rf_write_data,
    output logic                      rf_write_enable,
    input  logic [REG_WIDTH-1:0]      rf_read_data
);

    localparam int unsigned IW = idx_width(NREQ);

    logic                  run_q;
    logic [IW-1:0]         rr_ptr;
    logic [NREQ-1:0]       req_live;
    logic [NREQ-1:0]       grant;
    logic [IW-1:0]         grant_idx;
    logic                  accept;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [REG_WIDTH-1:0]  sel_wdata;
    logic                  in_range;

    logic [ADDR_WIDTH-1:0] addr_arr  [NREQ];
    logic [REG_WIDTH-1:0]  wdata_arr [NREQ];

    // Unpack the per-requester address and data slices.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[slice_lsb(g, ADDR_WIDTH) +: ADDR_WIDTH];
        assign wdata_arr[g] = req_wdata[slice_lsb(g, REG_WIDTH) +: REG_WIDTH];
    end

    // Requests are ignored until the first clock edge after reset release.
    assign req_live = req_valid & {NREQ{run_q}};

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_arbiter (
        .req       (req_live),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Select the grantee's command; zero when nothing is accepted.
    always_comb begin
        accept    = |grant;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (accept) begin
            sel_we    = req_we[grant_idx];
            sel_addr  = addr_arr[grant_idx];
            sel_wdata = wdata_arr[grant_idx];
        end
        in_range = (32'(sel_addr) < REG_DEPTH);
    end

    always_comb begin
        req_ready        = grant;
        rf_write_enable  = accept && sel_we && in_range;
        rf_write_address = sel_addr;
        rf_write_data    = sel_wdata;
        rf_read_address  = (accept && !sel_we) ? sel_addr : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= IW'(wrap_inc(32'(grant_idx), NREQ));
        end
    end

    // Completion: data is captured at the accept edge; writes and errors return zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= grant;
            rsp_err   <= accept && !in_range;
            if (accept) begin
                rsp_rdata <= (!sel_we && in_range) ? rf_read_data : '0;
            end
        end
    end

endmodule

// File: tb/tb_scalar_rf_arbiter.sv
// Directed bench for scalar_rf_arbiter with a behavioural register file attached.
// Vector table covers arbitration, read/write paths and range errors; reset cases are sequenced by hand.
module tb_scalar_rf_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned DEPTH = 6;
    localparam int unsigned RW = 32;
    localparam int unsigned AW = 5;

    logic              clk;
    logic              reset_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*RW-1:0] req_wdata;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [RW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [AW-1:0]     rf_read_address;
    logic [AW-1:0]     rf_write_address;
    logic [RW-1:0]     rf_write_data;
    logic              rf_write_enable;
    logic [RW-1:0]     rf_read_data;

    int checks = 0;
    int failures = 0;

    scalar_rf_arbiter #(
        .NREQ       (NREQ),
        .REG_DEPTH  (DEPTH),
        .REG_WIDTH  (RW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_we           (req_we),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err),
        .rf_read_address  (rf_read_address),
        .rf_write_address (rf_write_address),
        .rf_write_data    (rf_write_data),
        .rf_write_enable  (rf_write_enable),
        .rf_read_data     (rf_read_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file model: unwritten entries read zero below DEPTH and a marker pattern above it.
    logic [RW-1:0] rf_mem [32];
    logic [31:0]   rf_written = '0;

    always @(posedge clk) begin
        if (rf_write_enable) begin
            rf_mem[rf_write_address]     <= rf_write_data;
            rf_written[rf_write_address] <= 1'b1;
        end
    end

    always_comb begin
        if (rf_written[rf_read_address])
            rf_read_data = rf_mem[rf_read_address];
        else if (32'(rf_read_address) >= DEPTH)
            rf_read_data = 32'hA5A50000 | 32'(rf_read_address);
        else
            rf_read_data = '0;
    end

    typedef struct {
        string           name;
        logic [2:0]      valid;
        logic [2:0]      we;
        logic [AW-1:0]   a0, a1, a2;
        logic [RW-1:0]   w0, w1, w2;
        logic [2:0]      exp_ready;
        logic            exp_wen;
        logic [AW-1:0]   exp_waddr;
        logic [RW-1:0]   exp_wdata;
        logic [AW-1:0]   exp_raddr;
        logic [2:0]      exp_rsp;
        logic            exp_err;
        logic [RW-1:0]   exp_rdata;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input string name, input logic [2:0] valid, input logic [2:0] we,
                                input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                input logic [RW-1:0] w0, input logic [RW-1:0] w1, input logic [RW-1:0] w2,
                                input logic [2:0] rdy, input logic wen, input logic [AW-1:0] waddr,
                                input logic [RW-1:0] wdata, input logic [AW-1:0] raddr,
                                input logic [2:0] rsp, input logic err, input logic [RW-1:0] rdata);
        vec_t v;
        v.name = name; v.valid = valid; v.we = we;
        v.a0 = a0; v.a1 = a1; v.a2 = a2; v.w0 = w0; v.w1 = w1; v.w2 = w2;
        v.exp_ready = rdy; v.exp_wen = wen; v.exp_waddr = waddr; v.exp_wdata = wdata;
        v.exp_raddr = raddr; v.exp_rsp = rsp; v.exp_err = err; v.exp_rdata = rdata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] valid, input logic [2:0] we,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [RW-1:0] w0, input logic [RW-1:0] w1, input logic [RW-1:0] w2);
        req_valid = valid;
        req_we    = we;
        req_addr  = {a2, a1, a0};
        req_wdata = {w2, w1, w0};
    endtask

    // One cycle: drive at negedge, check accept-cycle outputs, then the response after the edge.
    task automatic step(input vec_t v);
        @(negedge clk);
        drive(v.valid, v.we, v.a0, v.a1, v.a2, v.w0, v.w1, v.w2);
        #1;
        chk({v.name, ".ready"}, 64'(req_ready), 64'(v.exp_ready));
        chk({v.name, ".wen"}, 64'(rf_write_enable), 64'(v.exp_wen));
        chk({v.name, ".raddr"}, 64'(rf_read_address), 64'(v.exp_raddr));
        if (v.exp_wen) begin
            chk({v.name, ".waddr"}, 64'(rf_write_address), 64'(v.exp_waddr));
            chk({v.name, ".wdata"}, 64'(rf_write_data), 64'(v.exp_wdata));
        end
        @(posedge clk);
        #1;
        chk({v.name, ".rsp_valid"}, 64'(rsp_valid), 64'(v.exp_rsp));
        chk({v.name, ".rsp_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
        if (v.exp_rsp != 3'b000)
            chk({v.name, ".rsp_err"}, 64'(rsp_err), 64'(v.exp_err));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".ready"}, 64'(req_ready), 64'd0);
        chk({nm, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({nm, ".rsp_err"}, 64'(rsp_err), 64'd0);
        chk({nm, ".rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        chk({nm, ".wen"}, 64'(rf_write_enable), 64'd0);
        chk({nm, ".raddr"}, 64'(rf_read_address), 64'd0);
    endtask

    initial begin
        // Round robin from reset with all three valid.
        vecs.push_back(mk("rr0", 3'b111, 3'b000, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0, 3'b001, 0, 0));
        vecs.push_back(mk("rr1", 3'b111, 3'b000, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0, 3'b010, 0, 0));
        vecs.push_back(mk("rr2", 3'b111, 3'b000, 0, 0, 0, 0, 0, 0, 3'b100, 0, 0, 0, 0, 3'b100, 0, 0));
        vecs.push_back(mk("rr3", 3'b111, 3'b000, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0, 3'b001, 0, 0));
        vecs.push_back(mk("rr4", 3'b111, 3'b000, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0, 3'b010, 0, 0));
        vecs.push_back(mk("rr5", 3'b111, 3'b000, 0, 0, 0, 0, 0, 0, 3'b100, 0, 0, 0, 0, 3'b100, 0, 0));
        // Write then read-back by another requester.
        vecs.push_back(mk("wr0_a3", 3'b001, 3'b001, 3, 0, 0, 32'hDEADBEEF, 0, 0, 3'b001, 1, 3, 32'hDEADBEEF, 0, 3'b001, 0, 0));
        vecs.push_back(mk("rd1_a3", 3'b010, 3'b000, 0, 3, 0, 0, 0, 0, 3'b010, 0, 0, 0, 3, 3'b010, 0, 32'hDEADBEEF));
        // Out-of-range write.
        vecs.push_back(mk("wr_oob6", 3'b001, 3'b001, 6, 0, 0, 32'h12345678, 0, 0, 3'b001, 0, 0, 0, 0, 3'b001, 1, 0));
        vecs.push_back(mk("idle0", 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0));
        // Back-to-back write then read of the same register.
        vecs.push_back(mk("wr2_a1", 3'b100, 3'b100, 0, 0, 1, 0, 0, 32'h5, 3'b100, 1, 1, 32'h5, 0, 3'b100, 0, 0));
        vecs.push_back(mk("rd2_a1", 3'b100, 3'b000, 0, 0, 1, 0, 0, 0, 3'b100, 0, 0, 0, 1, 3'b100, 0, 32'h5));
        vecs.push_back(mk("idle_hold", 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 32'h5));
        // Single requester streaming at full rate.
        vecs.push_back(mk("s1_0", 3'b010, 3'b000, 0, 3, 0, 0, 0, 0, 3'b010, 0, 0, 0, 3, 3'b010, 0, 32'hDEADBEEF));
        vecs.push_back(mk("s1_1", 3'b010, 3'b000, 0, 1, 0, 0, 0, 0, 3'b010, 0, 0, 0, 1, 3'b010, 0, 32'h5));
        vecs.push_back(mk("s1_2", 3'b010, 3'b000, 0, 3, 0, 0, 0, 0, 3'b010, 0, 0, 0, 3, 3'b010, 0, 32'hDEADBEEF));
        vecs.push_back(mk("s1_3", 3'b010, 3'b000, 0, 1, 0, 0, 0, 0, 3'b010, 0, 0, 0, 1, 3'b010, 0, 32'h5));
        // Pointer wrap with two contenders.
        vecs.push_back(mk("cont0", 3'b011, 3'b000, 1, 3, 0, 0, 0, 0, 3'b001, 0, 0, 0, 1, 3'b001, 0, 32'h5));
        vecs.push_back(mk("cont1", 3'b011, 3'b000, 1, 3, 0, 0, 0, 0, 3'b010, 0, 0, 0, 3, 3'b010, 0, 32'hDEADBEEF));
        // Out-of-range read returns zero with error.
        vecs.push_back(mk("rd_oob31", 3'b100, 3'b000, 0, 0, 31, 0, 0, 0, 3'b100, 0, 0, 0, 31, 3'b100, 1, 0));
        vecs.push_back(mk("wr0_a5", 3'b101, 3'b001, 5, 0, 5, 32'h0BADF00D, 0, 0, 3'b001, 1, 5, 32'h0BADF00D, 0, 3'b001, 0, 0));
        vecs.push_back(mk("rd2_a5", 3'b100, 3'b000, 0, 0, 5, 0, 0, 0, 3'b100, 0, 0, 0, 5, 3'b100, 0, 32'h0BADF00D));
        vecs.push_back(mk("rd0_a0", 3'b001, 3'b000, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0, 3'b001, 0, 0));

        // Reset with all requesters already valid.
        reset_n = 1'b0;
        drive(3'b111, 3'b000, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("in_reset");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("pre_first_edge.ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("first_edge.rsp_valid", 64'(rsp_valid), 64'd0);

        foreach (vecs[i]) step(vecs[i]);

        // Reset lands on the edge that would register a read response.
        @(negedge clk);
        drive(3'b010, 3'b000, 0, 3, 0, 0, 0, 0);
        #1;
        chk("mid_rst_accept.ready", 64'(req_ready), 64'(3'b010));
        chk("mid_rst_accept.raddr", 64'(rf_read_address), 64'd3);
        @(posedge clk);
        reset_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        // Writes requested during reset must not reach the register file.
        @(negedge clk);
        drive(3'b001, 3'b001, 2, 0, 0, 32'hFFFFFFFF, 0, 0);
        #1;
        chk("rst_write.wen", 64'(rf_write_enable), 64'd0);
        chk("rst_write.ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_write.rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(3'b111, 3'b000, 2, 0, 0, 0, 0, 0);
        @(posedge clk);
        // Pointer restarts at 0, and addr 2 was never written.
        @(negedge clk);
        #1;
        chk("post_rst.ready", 64'(req_ready), 64'(3'b001));
        chk("post_rst.raddr", 64'(rf_read_address), 64'd2);
        @(posedge clk);
        #1;
        chk("post_rst.rsp_valid", 64'(rsp_valid), 64'(3'b001));
        chk("post_rst.rsp_rdata", 64'(rsp_rdata), 64'd0);

        @(negedge clk);
        drive(3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
